// File: rtl/data_obi_arbiter.sv
// ---------------------------------------------------------------------------
// data_obi_arbiter
//   Shares one OBI data-memory port between the scalar core LSU (port C) and
//   the vector LSU (port V). A requester is picked with zero latency while
//   idle and that pick is frozen until its grant, so the OBI request seen by
//   memory stays stable. Every accepted transaction pushes its owner into a
//   small FIFO, and the in-order responses are routed back by popping it.
//   While v_lock_i is high the vector LSU has exclusive use of the port.
//
// Ports
//   clk, n_reset                 clock, synchronous active-low reset
//   c_* / v_*  (inputs)          OBI request channel of core / vector LSU
//   c_gnt_o / v_gnt_o            grant back to the selected requester
//   c_rvalid_o / v_rvalid_o      response valid routed to the owner
//   c_rdata_o / v_rdata_o        read data (both carry mem_rdata_i)
//   v_lock_i                     exclusive-access lock from the vector LSU
//   mem_*                        OBI manager port towards memory
//   outstanding_o                number of accepted, unanswered transactions
//   err_o                        sticky: response seen with nothing outstanding
// ---------------------------------------------------------------------------
module data_obi_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic                                 clk,
    input  logic                                 n_reset,

    // core LSU port
    input  logic                                 c_req_i,
    input  logic                                 c_we_i,
    input  logic [DATA_W/8-1:0]                  c_be_i,
    input  logic [ADDR_W-1:0]                    c_addr_i,
    input  logic [DATA_W-1:0]                    c_wdata_i,
    output logic                                 c_gnt_o,
    output logic                                 c_rvalid_o,
    output logic [DATA_W-1:0]                    c_rdata_o,

    // vector LSU port
    input  logic                                 v_req_i,
    input  logic                                 v_we_i,
    input  logic [DATA_W/8-1:0]                  v_be_i,
    input  logic [ADDR_W-1:0]                    v_addr_i,
    input  logic [DATA_W-1:0]                    v_wdata_i,
    output logic                                 v_gnt_o,
    output logic                                 v_rvalid_o,
    output logic [DATA_W-1:0]                    v_rdata_o,
    input  logic                                 v_lock_i,

    // memory port
    output logic                                 mem_req_o,
    input  logic                                 mem_gnt_i,
    output logic                                 mem_we_o,
    output logic [DATA_W/8-1:0]                  mem_be_o,
    output logic [ADDR_W-1:0]                    mem_addr_o,
    output logic [DATA_W-1:0]                    mem_wdata_o,
    input  logic                                 mem_rvalid_i,
    input  logic [DATA_W-1:0]                    mem_rdata_i,

    // status
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Owner encoding stored in the FIFO and in last_owner.
    localparam logic OWNER_C = 1'b0;
    localparam logic OWNER_V = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_C = 2'd1,
        ARB_HOLD_V = 2'd2
    } arb_state_e;

    arb_state_e         state_q,      state_d;
    logic               last_owner_q, last_owner_d;
    logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]   count_q,      count_d;
    logic               err_q,        err_d;
    logic               owner_q [MAX_OUTSTANDING];

    logic               accept;
    logic               sel_v;
    logic               sel_req;
    logic               handshake;
    logic               push;
    logic               pop;
    logic               head_owner;

    // Circular pointer increment over MAX_OUTSTANDING entries.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // A slot is free only on the registered count; a same-cycle pop does not help.
    assign accept = (count_q < CNT_W'(MAX_OUTSTANDING));

    // Requester selection and next-state logic.
    always_comb begin
        state_d = state_q;
        sel_v   = OWNER_C;
        sel_req = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (v_lock_i) begin
                    sel_v   = OWNER_V;
                    sel_req = v_req_i;
                end else if (c_req_i && v_req_i) begin
                    // Round-robin: whoever did not win last time.
                    sel_v   = (last_owner_q == OWNER_C) ? OWNER_V : OWNER_C;
                    sel_req = 1'b1;
                end else if (v_req_i) begin
                    sel_v   = OWNER_V;
                    sel_req = 1'b1;
                end else if (c_req_i) begin
                    sel_v   = OWNER_C;
                    sel_req = 1'b1;
                end
            end
            ARB_HOLD_C: begin
                sel_v   = OWNER_C;
                sel_req = c_req_i;
            end
            ARB_HOLD_V: begin
                sel_v   = OWNER_V;
                sel_req = v_req_i;
            end
            default: begin
                sel_v   = OWNER_C;
                sel_req = 1'b0;
            end
        endcase

        mem_req_o = sel_req & accept;
        handshake = mem_req_o & mem_gnt_i;

        // Without a free slot nothing is offered, so the current pick is kept.
        unique case (state_q)
            ARB_IDLE: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d = (sel_v == OWNER_V) ? ARB_HOLD_V : ARB_HOLD_C;
                end
            end
            ARB_HOLD_C, ARB_HOLD_V: begin
                // A dropped request is an OBI violation; release the hold anyway.
                if (accept && (handshake || !sel_req)) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Request-field mux and grant steering.
    always_comb begin
        mem_we_o    = (sel_v == OWNER_V) ? v_we_i    : c_we_i;
        mem_be_o    = (sel_v == OWNER_V) ? v_be_i    : c_be_i;
        mem_addr_o  = (sel_v == OWNER_V) ? v_addr_i  : c_addr_i;
        mem_wdata_o = (sel_v == OWNER_V) ? v_wdata_i : c_wdata_i;
        c_gnt_o     = handshake & (sel_v == OWNER_C);
        v_gnt_o     = handshake & (sel_v == OWNER_V);
    end

    // Response routing from the head of the owner FIFO.
    always_comb begin
        push       = handshake;
        pop        = mem_rvalid_i & (count_q != '0);
        head_owner = owner_q[rd_ptr_q];
        c_rvalid_o = pop & (head_owner == OWNER_C);
        v_rvalid_o = pop & (head_owner == OWNER_V);
    end

    assign c_rdata_o = mem_rdata_i;
    assign v_rdata_o = mem_rdata_i;

    // Owner FIFO bookkeeping, round-robin history and the sticky error.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_owner_d = last_owner_q;
        err_d        = err_q;

        if (push) begin
            wr_ptr_d     = ptr_inc(wr_ptr_q);
            last_owner_d = sel_v;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (mem_rvalid_i && (count_q == '0)) begin
            err_d = 1'b1;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= OWNER_V;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end

    // Owner storage; entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_q[wr_ptr_q] <= sel_v;
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_data_obi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_obi_arbiter
//   Cycle-by-cycle vectors for data_obi_arbiter. Each row drives one cycle of
//   requests / memory handshake and lists the expected grants, memory request,
//   routed responses and status. Expected response owners are queued when a
//   grant is expected and popped when the DUT routes a response.
// ---------------------------------------------------------------------------
module tb_data_obi_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_OUT = 2;

    localparam logic [31:0] C_ADDR  = 32'h0000_0100;
    localparam logic [31:0] V_ADDR  = 32'h0000_0200;
    localparam logic [31:0] C_WDATA = 32'hC0C0_C0C0;
    localparam logic [31:0] V_WDATA = 32'h5A5A_5A5A;
    localparam logic [3:0]  C_BE    = 4'hF;
    localparam logic [3:0]  V_BE    = 4'h3;

    // in  = {c_req, v_req, v_lock, mem_gnt, mem_rvalid}
    // exp = {c_gnt, v_gnt, mem_req, sel_is_v, c_rvalid, v_rvalid}
    typedef struct {
        logic [4:0]  in;
        logic [31:0] rd;
        logic [5:0]  exp;
        logic [1:0]  outst;
        logic        err;
    } vec_t;

    logic                clk = 1'b0;
    logic                n_reset;
    logic                c_req_i, c_we_i, v_req_i, v_we_i, v_lock_i;
    logic [DATA_W/8-1:0] c_be_i, v_be_i, mem_be_o;
    logic [ADDR_W-1:0]   c_addr_i, v_addr_i, mem_addr_o;
    logic [DATA_W-1:0]   c_wdata_i, v_wdata_i, mem_wdata_o;
    logic                c_gnt_o, v_gnt_o, c_rvalid_o, v_rvalid_o;
    logic [DATA_W-1:0]   c_rdata_o, v_rdata_o, mem_rdata_i;
    logic                mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [1:0]          outstanding_o;
    logic                err_o;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs[$];
    logic sb_q[$];

    always #5 clk = ~clk;

    data_obi_arbiter #(
        .MAX_OUTSTANDING (MAX_OUT),
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .c_req_i       (c_req_i),
        .c_we_i        (c_we_i),
        .c_be_i        (c_be_i),
        .c_addr_i      (c_addr_i),
        .c_wdata_i     (c_wdata_i),
        .c_gnt_o       (c_gnt_o),
        .c_rvalid_o    (c_rvalid_o),
        .c_rdata_o     (c_rdata_o),
        .v_req_i       (v_req_i),
        .v_we_i        (v_we_i),
        .v_be_i        (v_be_i),
        .v_addr_i      (v_addr_i),
        .v_wdata_i     (v_wdata_i),
        .v_gnt_o       (v_gnt_o),
        .v_rvalid_o    (v_rvalid_o),
        .v_rdata_o     (v_rdata_o),
        .v_lock_i      (v_lock_i),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    function automatic void add(input logic [4:0] in, input logic [31:0] rd,
                                input logic [5:0] exp, input logic [1:0] outst,
                                input logic err);
        vec_t v;
        v.in    = in;
        v.rd    = rd;
        v.exp   = exp;
        v.outst = outst;
        v.err   = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_inputs();
        c_req_i      = 1'b0;
        v_req_i      = 1'b0;
        v_lock_i     = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    // Drive one cycle, compare at the falling edge, advance past the rising edge.
    task automatic run_vec(input vec_t v, input int row);
        logic exp_owner;
        c_req_i      = v.in[4];
        v_req_i      = v.in[3];
        v_lock_i     = v.in[2];
        mem_gnt_i    = v.in[1];
        mem_rvalid_i = v.in[0];
        mem_rdata_i  = v.rd;
        @(negedge clk);

        if (c_rvalid_o || v_rvalid_o) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow row %0d: got rvalid c=%0b v=%0b, expected no response",
                         row, c_rvalid_o, v_rvalid_o);
            end else begin
                exp_owner = sb_q.pop_front();
                chk("sb_owner", row, 32'(v_rvalid_o), 32'(exp_owner));
                chk("sb_rdata", row, exp_owner ? v_rdata_o : c_rdata_o, v.rd);
            end
        end

        chk("c_gnt",    row, 32'(c_gnt_o),    32'(v.exp[5]));
        chk("v_gnt",    row, 32'(v_gnt_o),    32'(v.exp[4]));
        chk("mem_req",  row, 32'(mem_req_o),  32'(v.exp[3]));
        chk("c_rvalid", row, 32'(c_rvalid_o), 32'(v.exp[1]));
        chk("v_rvalid", row, 32'(v_rvalid_o), 32'(v.exp[0]));
        if (v.exp[3]) begin
            chk("mem_addr",  row, mem_addr_o,  v.exp[2] ? V_ADDR  : C_ADDR);
            chk("mem_wdata", row, mem_wdata_o, v.exp[2] ? V_WDATA : C_WDATA);
            chk("mem_we_be", row, 32'({mem_we_o, mem_be_o}),
                v.exp[2] ? 32'({1'b1, V_BE}) : 32'({1'b0, C_BE}));
        end
        chk("outstanding", row, 32'(outstanding_o), 32'(v.outst));
        chk("err",         row, 32'(err_o),         32'(v.err));

        if (v.exp[5]) sb_q.push_back(1'b0);
        if (v.exp[4]) sb_q.push_back(1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_main;

        // single core read
        add(5'b10010, 32'h0,         6'b101000, 2'd0, 1'b0);
        add(5'b00000, 32'h0,         6'b000000, 2'd1, 1'b0);
        add(5'b00001, 32'hDEADBEEF,  6'b000010, 2'd1, 1'b0);
        add(5'b00000, 32'h0,         6'b000000, 2'd0, 1'b0);
        // V access so last owner is V, then V held for 3 wait cycles while C rises
        add(5'b01010, 32'h0,         6'b011100, 2'd0, 1'b0);
        add(5'b00001, 32'h11111111,  6'b000001, 2'd1, 1'b0);
        add(5'b01000, 32'h0,         6'b001100, 2'd0, 1'b0);
        add(5'b11000, 32'h0,         6'b001100, 2'd0, 1'b0);
        add(5'b11000, 32'h0,         6'b001100, 2'd0, 1'b0);
        add(5'b11010, 32'h0,         6'b011100, 2'd0, 1'b0);
        add(5'b10010, 32'h0,         6'b101000, 2'd1, 1'b0);
        add(5'b00001, 32'h22222222,  6'b000001, 2'd2, 1'b0);
        add(5'b00001, 32'h33333333,  6'b000010, 2'd1, 1'b0);
        add(5'b00000, 32'h0,         6'b000000, 2'd0, 1'b0);
        // lock: four V grants while C waits, C once lock drops, C response under lock
        add(5'b11110, 32'h0,         6'b011100, 2'd0, 1'b0);
        add(5'b11111, 32'h44444444,  6'b011101, 2'd1, 1'b0);
        add(5'b11111, 32'h55555555,  6'b011101, 2'd1, 1'b0);
        add(5'b11111, 32'h66666666,  6'b011101, 2'd1, 1'b0);
        add(5'b10011, 32'h77777777,  6'b101001, 2'd1, 1'b0);
        add(5'b00101, 32'h88888888,  6'b000010, 2'd1, 1'b0);
        add(5'b00000, 32'h0,         6'b000000, 2'd0, 1'b0);
        // full FIFO blocks a third request; pop does not free a slot; spurious rvalid
        add(5'b10010, 32'h0,         6'b101000, 2'd0, 1'b0);
        add(5'b01010, 32'h0,         6'b011100, 2'd1, 1'b0);
        add(5'b10010, 32'h0,         6'b000000, 2'd2, 1'b0);
        add(5'b10011, 32'hAAAA0001,  6'b000010, 2'd2, 1'b0);
        add(5'b00001, 32'hAAAA0002,  6'b000001, 2'd1, 1'b0);
        add(5'b00001, 32'hBAD0BAD0,  6'b000000, 2'd0, 1'b0);
        add(5'b00000, 32'h0,         6'b000000, 2'd0, 1'b1);
        // fill to two outstanding with C last, ahead of a mid-transaction reset
        add(5'b01010, 32'h0,         6'b011100, 2'd0, 1'b1);
        add(5'b10010, 32'h0,         6'b101000, 2'd1, 1'b1);
        n_main = vecs.size();
        // tie after reset: C,V,C,V with responses routed in grant order
        add(5'b11010, 32'h0,         6'b101000, 2'd0, 1'b0);
        add(5'b11011, 32'hC0000001,  6'b011110, 2'd1, 1'b0);
        add(5'b11011, 32'hC0000002,  6'b101001, 2'd1, 1'b0);
        add(5'b11011, 32'hC0000003,  6'b011110, 2'd1, 1'b0);
        add(5'b00001, 32'hC0000004,  6'b000001, 2'd1, 1'b0);
        add(5'b00000, 32'h0,         6'b000000, 2'd0, 1'b0);

        c_we_i    = 1'b0;  c_be_i = C_BE;  c_addr_i = C_ADDR;  c_wdata_i = C_WDATA;
        v_we_i    = 1'b1;  v_be_i = V_BE;  v_addr_i = V_ADDR;  v_wdata_i = V_WDATA;
        clear_inputs();
        n_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;

        @(negedge clk);
        chk("rst_mem_req",  -1, 32'(mem_req_o),     32'd0);
        chk("rst_gnt",      -1, 32'({c_gnt_o, v_gnt_o}), 32'd0);
        chk("rst_rvalid",   -1, 32'({c_rvalid_o, v_rvalid_o}), 32'd0);
        chk("rst_outst",    -1, 32'(outstanding_o), 32'd0);
        chk("rst_err",      -1, 32'(err_o),         32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < n_main; i++) begin
            run_vec(vecs[i], i);
        end

        // reset with two transactions outstanding and err set
        clear_inputs();
        n_reset = 1'b0;
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("midrst_outst",   -2, 32'(outstanding_o), 32'd0);
        chk("midrst_err",     -2, 32'(err_o),         32'd0);
        chk("midrst_mem_req", -2, 32'(mem_req_o),     32'd0);
        @(posedge clk);
        #1;

        for (int i = n_main; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        chk("sb_drain", -3, 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
